// File: rtl/synth_pkg.sv
// synth_pkg: shared sample width and sample buffer sizing for the synthesis engine.
package synth_pkg;
   localparam int SAMPLE_W = 16;
   localparam int SAMPLE_FIFO_DEPTH_LOG2 = 3;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_tick_mem.sv
// sample_tick_mem: simple dual-port register array, synchronous write, asynchronous read.
module sample_tick_mem
   import synth_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int ADDR_W = SAMPLE_FIFO_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/sample_tick_fifo.sv
// sample_tick_fifo: engine-to-tick sample buffer, one pop per tick, underrun pulse on empty tick.
// SAMPLE_HOLD_EN: when defined, an underrun repeats the last sample instead of outputting zero.
module sample_tick_fifo
   import synth_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH_LOG2 = SAMPLE_FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  tick,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_strobe,
   output logic                  underrun,
   output logic [DEPTH_LOG2:0]   level
);
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic [DATA_W-1:0]     rdata, ur_data;
   logic                  wr, rd, ur;
   assign in_ready = count != FULL;
   assign level    = count;
   assign wr       = in_valid && in_ready;
   assign rd       = tick && count != '0;
   assign ur       = tick && count == '0;
`ifdef SAMPLE_HOLD_EN
   assign ur_data = out_data;
`else
   assign ur_data = '0;
`endif
   sample_tick_mem #(.DATA_W(DATA_W), .ADDR_W(DEPTH_LOG2)) u_mem (
      .clk(clk), .we(wr), .waddr(wr_ptr), .wdata(in_data), .raddr(rd_ptr), .rdata(rdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         out_data   <= '0;
         out_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count      <= (wr && !rd) ? count + 1'b1 : (rd && !wr) ? count - 1'b1 : count;
         out_data   <= rd ? rdata : ur ? ur_data : out_data;
         out_strobe <= rd;
         underrun   <= ur;
      end
   end
endmodule

// File: tb/tb_sample_tick_fifo.sv
// tb_sample_tick_fifo: directed plan plus randomized traffic against a queue-based reference model.
module tb_sample_tick_fifo;
   localparam int DW = 16;
`ifdef SAMPLE_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, tick = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_strobe, underrun;
   logic [DW-1:0] out_data;
   logic [3:0] level;
   int tests = 0, fails = 0;
   bit chk = 1'b0;
   sample_tick_fifo dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tick(tick), .out_data(out_data), .out_strobe(out_strobe), .underrun(underrun), .level(level)
   );
   always #5 clk = ~clk;
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_out = '0;
   bit m_strobe = 1'b0, m_ur = 1'b0;
   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         q.delete();
         m_out = '0;
         m_strobe = 1'b0;
         m_ur = 1'b0;
      end else begin
         acc = in_valid && q.size() < 8;
         m_strobe = 1'b0;
         m_ur = 1'b0;
         if (tick) begin
            if (q.size() > 0) begin
               m_out = q.pop_front();
               m_strobe = 1'b1;
            end else begin
               m_ur = 1'b1;
               if (!HOLD) m_out = '0;
            end
         end
         if (acc) q.push_back(in_data);
      end
   end
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (chk) begin
      check("model out_data", 32'(out_data), 32'(m_out));
      check("model out_strobe", 32'(out_strobe), 32'(m_strobe));
      check("model underrun", 32'(underrun), 32'(m_ur));
      check("model level", 32'(level), 32'(q.size()));
      check("model in_ready", 32'(in_ready), 32'(q.size() < 8));
   end
   task automatic cyc(bit v, logic [DW-1:0] d, bit t);
      in_valid = v;
      in_data = d;
      tick = t;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      tick = 1'b0;
   endtask
   initial begin
      rst = 1'b1;
      cyc(0, 0, 0);
      chk = 1'b1;
      check("reset level", 32'(level), 0);
      check("reset in_ready", 32'(in_ready), 1);
      check("reset out_data", 32'(out_data), 0);
      check("reset strobe", 32'(out_strobe), 0);
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) cyc(1, DW'(i), 0);
      check("push3 level", 32'(level), 3);
      check("push3 in_ready", 32'(in_ready), 1);
      cyc(0, 0, 1);
      check("first pop data", 32'(out_data), 32'h1);
      check("first pop strobe", 32'(out_strobe), 1);
      check("first pop level", 32'(level), 2);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      check("drain data", 32'(out_data), 32'h3);
      for (int i = 0; i < 8; i++) cyc(1, DW'(16 + i), 0);
      check("full level", 32'(level), 8);
      check("full in_ready", 32'(in_ready), 0);
      cyc(1, 16'h0099, 0);
      check("ninth rejected level", 32'(level), 8);
      cyc(0, 0, 1);
      check("after full pop data", 32'(out_data), 32'h10);
      check("after full pop level", 32'(level), 7);
      check("after full pop in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1);
      check("full drain last", 32'(out_data), 32'h17);
      cyc(1, 16'h1234, 0);
      cyc(0, 0, 1);
      check("pre-underrun data", 32'(out_data), 32'h1234);
      cyc(0, 0, 1);
      check("underrun flag", 32'(underrun), 1);
      check("underrun strobe", 32'(out_strobe), 0);
      check("underrun data", 32'(out_data), HOLD ? 32'h1234 : 32'h0);
      check("underrun level", 32'(level), 0);
      cyc(0, 0, 0);
      check("underrun pulse ends", 32'(underrun), 0);
      cyc(1, 16'h000A, 0);
      cyc(1, 16'h000B, 0);
      cyc(1, 16'h00AA, 1);
      check("simul level", 32'(level), 2);
      check("simul data", 32'(out_data), 32'h0A);
      for (int i = 0; i < 20; i++) begin
         cyc(1, DW'(16'h0100 + i), 1);
         check("wrap order", 32'(out_data), i == 0 ? 32'h0B : i == 1 ? 32'hAA : 32'(16'h0100 + i - 2));
         check("wrap level", 32'(level), 2);
      end
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      check("wrap drained", 32'(level), 0);
      cyc(1, 16'h0055, 1);
      check("no fall-through underrun", 32'(underrun), 1);
      check("no fall-through level", 32'(level), 1);
      cyc(0, 0, 1);
      check("queued after underrun", 32'(out_data), 32'h55);
      check("queued strobe", 32'(out_strobe), 1);
      for (int i = 0; i < 5; i++) cyc(1, DW'(16'h0200 + i), 0);
      check("pre-reset level", 32'(level), 5);
      rst = 1'b1;
      cyc(0, 0, 1);
      rst = 1'b0;
      check("mid reset level", 32'(level), 0);
      check("mid reset strobe", 32'(out_strobe), 0);
      check("mid reset underrun", 32'(underrun), 0);
      check("mid reset data", 32'(out_data), 0);
      check("mid reset in_ready", 32'(in_ready), 1);
      cyc(0, 0, 1);
      check("post reset underrun", 32'(underrun), 1);
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         cyc($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 2) == 0 || (i / 100) % 2 == 1);
      end
      rst = 1'b0;
      chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
